// File: rtl/mem_access.sv
// Memory-access stage: takes one instruction's execute results, performs at
// most one aligned word load/store over a req/ack data-memory port, and
// presents writeback and branch results with a one-cycle done pulse.
//
// Data-memory handshake: dmem_req is a level held from the launch edge
// until the first clock edge at which dmem_ack is sampled high (or the wait
// times out). dmem_we, dmem_addr and dmem_wdata are stable the whole time
// dmem_req is high. dmem_rdata is used only at the edge where dmem_ack=1.
// dmem_ack is ignored whenever the stage is not waiting on memory.
module mem_access #(
    parameter logic [2:0] STATE_MEM = 3'd3,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [4:0]  write_reg_in,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] reg_write_data_in,
    input  logic        branch_in,
    input  logic [31:0] branch_addr_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        reg_write_out,
    output logic [4:0]  write_reg_out,
    output logic [31:0] reg_write_data_out,
    output logic        branch_out,
    output logic [31:0] branch_addr_out,
    output logic        done,
    output logic        mem_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fsm_t;

    // Last counter value before giving up on dmem_ack.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    fsm_t        fsm_q, fsm_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        req_d, we_d, rw_d, br_d, done_d, fault_d;
    logic [31:0] addr_d, wdata_d, data_d, baddr_d;
    logic [4:0]  wreg_d;

    logic        launch;
    logic        mem_op;
    logic        bad_op;

    assign launch    = (state == STATE_MEM);
    assign mem_op    = mem_read_in | mem_write_in;
    assign bad_op    = (mem_read_in & mem_write_in) |
                       (mem_op & (mem_addr[1:0] != 2'b00));
    assign dbg_state = fsm_q;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        req_d   = dmem_req;
        we_d    = dmem_we;
        addr_d  = dmem_addr;
        wdata_d = dmem_wdata;
        rw_d    = reg_write_out;
        wreg_d  = write_reg_out;
        data_d  = reg_write_data_out;
        br_d    = branch_out;
        baddr_d = branch_addr_out;
        fault_d = mem_fault;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (launch) begin
                    wreg_d  = write_reg_in;
                    br_d    = branch_in;
                    baddr_d = branch_addr_in;
                    fault_d = 1'b0;
                    if (bad_op) begin
                        fault_d = 1'b1;
                        rw_d    = 1'b0;
                        br_d    = 1'b0;
                        done_d  = 1'b1;
                        fsm_d   = S_HOLD;
                    end else if (mem_op) begin
                        req_d   = 1'b1;
                        we_d    = mem_write_in;
                        addr_d  = {mem_addr[31:2], 2'b00};
                        wdata_d = mem_write_data;
                        pend_d  = reg_write_in;
                        rw_d    = 1'b0;
                        cnt_d   = 8'd0;
                        fsm_d   = S_WAIT;
                    end else begin
                        rw_d    = reg_write_in;
                        data_d  = reg_write_data_in;
                        done_d  = 1'b1;
                        fsm_d   = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    req_d  = 1'b0;
                    if (dmem_we) begin
                        rw_d = 1'b0;
                    end else begin
                        rw_d   = pend_q;
                        data_d = dmem_rdata;
                    end
                    done_d = 1'b1;
                    fsm_d  = S_HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    rw_d    = 1'b0;
                    br_d    = 1'b0;
                    done_d  = 1'b1;
                    fsm_d   = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                // Wait for the controller to leave STATE_MEM so each visit
                // launches exactly once.
                if (!launch) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q              <= S_IDLE;
            cnt_q              <= 8'd0;
            pend_q             <= 1'b0;
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            dmem_addr          <= 32'd0;
            dmem_wdata         <= 32'd0;
            reg_write_out      <= 1'b0;
            write_reg_out      <= 5'd0;
            reg_write_data_out <= 32'd0;
            branch_out         <= 1'b0;
            branch_addr_out    <= 32'd0;
            done               <= 1'b0;
            mem_fault          <= 1'b0;
        end else begin
            fsm_q              <= fsm_d;
            cnt_q              <= cnt_d;
            pend_q             <= pend_d;
            dmem_req           <= req_d;
            dmem_we            <= we_d;
            dmem_addr          <= addr_d;
            dmem_wdata         <= wdata_d;
            reg_write_out      <= rw_d;
            write_reg_out      <= wreg_d;
            reg_write_data_out <= data_d;
            branch_out         <= br_d;
            branch_addr_out    <= baddr_d;
            done               <= done_d;
            mem_fault          <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// transactions compared against a rule-level reference model.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        mem_read_in, mem_write_in, reg_write_in, branch_in;
  logic [4:0]  write_reg_in;
  logic [31:0] mem_addr, mem_write_data, reg_write_data_in, branch_addr_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        reg_write_out, branch_out, done, mem_fault;
  logic [4:0]  write_reg_out;
  logic [31:0] reg_write_data_out, branch_addr_out;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];

  // observations from the last do_txn
  int          obs_done_cycle, obs_done_count, obs_req_cycles;
  bit          obs_req_after_done, obs_unstable, obs_wb_unstable;
  logic [31:0] obs_addr, obs_wdata, obs_data, obs_baddr;
  logic        obs_we, obs_rw, obs_br, obs_fault;
  logic [4:0]  obs_wreg;
  logic [1:0]  obs_dbg;

  typedef struct {
    logic        fault;
    int          req_cycles;
    int          done_cycle;
    logic        rw;
    logic        data_care;
    logic [31:0] data;
    logic        br;
  } exp_t;

  // clock / reset
  always #5 clk = ~clk;

  mem_access #(.STATE_MEM(3'd3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .state(state),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .reg_write_data_in(reg_write_data_in),
    .branch_in(branch_in), .branch_addr_in(branch_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .reg_write_out(reg_write_out), .write_reg_out(write_reg_out),
    .reg_write_data_out(reg_write_data_out),
    .branch_out(branch_out), .branch_addr_out(branch_addr_out),
    .done(done), .mem_fault(mem_fault), .dbg_state(dbg_state)
  );

  // Reference model: outcome of one instruction from the stage rules.
  // lat = number of req cycles before the memory acks (0 = never acks).
  function automatic exp_t model(input logic rd, input logic wr, input logic rw,
                                 input logic [31:0] addr, input logic [31:0] rwdata,
                                 input logic [31:0] rdata, input logic br, input int lat);
    exp_t e;
    bit   is_mem, bad, timed_out;
    is_mem = rd | wr;
    bad = (rd & wr) | (is_mem & (addr % 4 != 0));
    e.fault = 1'b0; e.req_cycles = 0; e.done_cycle = 1;
    e.rw = 1'b0; e.data_care = 1'b0; e.data = 32'd0; e.br = br;
    if (bad) begin
      e.fault = 1'b1; e.br = 1'b0;
    end else if (!is_mem) begin
      e.rw = rw; e.data_care = 1'b1; e.data = rwdata;
    end else begin
      timed_out = (lat == 0) || (lat > TMO);
      e.req_cycles = timed_out ? TMO : lat;
      e.done_cycle = e.req_cycles + 1;
      if (timed_out) begin
        e.fault = 1'b1; e.br = 1'b0;
      end else if (!wr) begin
        e.rw = rw; e.data_care = 1'b1; e.data = rdata;
      end
    end
    return e;
  endfunction

  // Driver: launches one instruction, plays the memory side, records what
  // the stage did, then leaves STATE_MEM so the stage returns to idle.
  task automatic do_txn(input logic rd, input logic wr, input logic rw,
                        input logic [4:0] wreg, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rwdata,
                        input logic br, input logic [31:0] baddr,
                        input logic [31:0] rdata, input int lat);
    int cyc, post, req_cnt;
    bit seen;
    obs_done_cycle = -1; obs_done_count = 0; obs_req_cycles = 0;
    obs_req_after_done = 0; obs_unstable = 0; obs_wb_unstable = 0;
    obs_addr = 0; obs_wdata = 0; obs_we = 0;
    @(negedge clk);
    state = 3'd3;
    mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    write_reg_in = wreg; mem_addr = addr; mem_write_data = wdata;
    reg_write_data_in = rwdata; branch_in = br; branch_addr_in = baddr;
    dmem_ack = 1'($urandom_range(0, 1));
    cyc = 0; post = 0; req_cnt = 0; seen = 0;
    while (cyc < 40 && !(seen && post >= 4)) begin
      @(negedge clk);
      cyc++;
      // scramble the launch inputs; they must have no further effect
      mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
      reg_write_in = 1'($urandom); write_reg_in = 5'($urandom);
      mem_addr = $urandom; mem_write_data = $urandom;
      reg_write_data_in = $urandom; branch_in = 1'($urandom);
      branch_addr_in = $urandom;
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          obs_addr = dmem_addr; obs_we = dmem_we; obs_wdata = dmem_wdata;
        end else if (dmem_addr !== obs_addr || dmem_we !== obs_we || dmem_wdata !== obs_wdata) begin
          obs_unstable = 1;
        end
        if (seen) obs_req_after_done = 1;
      end
      if (done) begin
        obs_done_count++;
        if (!seen) begin
          seen = 1; obs_done_cycle = cyc;
          obs_rw = reg_write_out; obs_wreg = write_reg_out;
          obs_data = reg_write_data_out; obs_br = branch_out;
          obs_baddr = branch_addr_out; obs_fault = mem_fault;
        end
      end else if (seen) begin
        post++;
        if (reg_write_out !== obs_rw || write_reg_out !== obs_wreg ||
            reg_write_data_out !== obs_data || branch_out !== obs_br ||
            branch_addr_out !== obs_baddr || mem_fault !== obs_fault)
          obs_wb_unstable = 1;
      end
      // memory side: ack in the lat-th req cycle; random noise while idle
      if (dmem_req) dmem_ack = (req_cnt == lat);
      else dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = dmem_ack ? rdata : $urandom;
    end
    obs_req_cycles = req_cnt;
    obs_dbg = dbg_state;
    state = 3'd0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; state = 3'd0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
    write_reg_in = 0; mem_addr = 0; mem_write_data = 0; reg_write_data_in = 0;
    branch_in = 0; branch_addr_in = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_write_out, write_reg_out,
         reg_write_data_out, branch_out, branch_addr_out, done, mem_fault} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero (req=%b done=%b fault=%b) want all 0", dmem_req, done, mem_fault);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    do_txn(0, 0, 1, 5'd5, $urandom, $urandom, 32'h2A, 0, 32'h1000, $urandom, 0);
    n_cmp++; if (obs_done_cycle !== 1) begin n_fail++; $display("FAIL alu_done_cycle: got %0d want 1", obs_done_cycle); end
    n_cmp++; if (obs_req_cycles !== 0) begin n_fail++; $display("FAIL alu_no_req: got %0d req cycles want 0", obs_req_cycles); end
    n_cmp++; if ({obs_rw, obs_wreg} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL alu_wb: got rw=%b reg=%0d want rw=1 reg=5", obs_rw, obs_wreg); end
    n_cmp++; if (obs_data !== 32'h2A) begin n_fail++; $display("FAIL alu_data: got %h want 0000002a", obs_data); end
    n_cmp++; if (obs_done_count !== 1) begin n_fail++; $display("FAIL alu_done_count: got %0d want 1", obs_done_count); end
  endtask

  task automatic test_load();
    do_txn(1, 0, 1, 5'd7, 32'h100, $urandom, $urandom, 1, 32'h2000, 32'hDEADBEEF, 3);
    n_cmp++; if (obs_req_cycles !== 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 3", obs_req_cycles); end
    n_cmp++; if ({obs_addr, obs_we} !== {32'h100, 1'b0}) begin n_fail++; $display("FAIL load_addr_we: got %h/%b want 00000100/0", obs_addr, obs_we); end
    n_cmp++; if (obs_data !== 32'hDEADBEEF || obs_rw !== 1'b1) begin n_fail++; $display("FAIL load_data: got %h rw=%b want deadbeef rw=1", obs_data, obs_rw); end
    n_cmp++; if (obs_done_cycle !== 4 || obs_done_count !== 1) begin n_fail++; $display("FAIL load_done: got cycle %0d count %0d want 4/1", obs_done_cycle, obs_done_count); end
    n_cmp++; if (obs_unstable !== 0) begin n_fail++; $display("FAIL load_req_stable: got %0d want 0", obs_unstable); end
    n_cmp++; if ({obs_br, obs_baddr} !== {1'b1, 32'h2000}) begin n_fail++; $display("FAIL load_branch: got %b/%h want 1/00002000", obs_br, obs_baddr); end
  endtask

  task automatic test_store();
    do_txn(0, 1, 1, 5'd3, 32'h44, 32'h12345678, $urandom, 0, 0, $urandom, 1);
    n_cmp++; if ({obs_we, obs_wdata, obs_addr} !== {1'b1, 32'h12345678, 32'h44}) begin n_fail++; $display("FAIL store_bus: got we=%b wd=%h a=%h want 1/12345678/00000044", obs_we, obs_wdata, obs_addr); end
    n_cmp++; if (obs_rw !== 1'b0) begin n_fail++; $display("FAIL store_no_wb: got %b want 0", obs_rw); end
    n_cmp++; if (obs_done_cycle !== 2) begin n_fail++; $display("FAIL store_done_cycle: got %0d want 2", obs_done_cycle); end
  endtask

  task automatic test_faults();
    do_txn(1, 0, 1, 5'd1, 32'h102, $urandom, $urandom, 1, $urandom, $urandom, 1);
    n_cmp++; if (obs_req_cycles !== 0 || obs_fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault: got req=%0d fault=%b want 0/1", obs_req_cycles, obs_fault); end
    n_cmp++; if (obs_rw !== 1'b0 || obs_br !== 1'b0 || obs_done_cycle !== 1) begin n_fail++; $display("FAIL misalign_resp: got rw=%b br=%b done@%0d want 0/0/1", obs_rw, obs_br, obs_done_cycle); end
    do_txn(1, 1, 1, 5'd2, 32'h80, $urandom, $urandom, 1, $urandom, $urandom, 1);
    n_cmp++; if (obs_req_cycles !== 0 || obs_fault !== 1'b1) begin n_fail++; $display("FAIL rdwr_fault: got req=%0d fault=%b want 0/1", obs_req_cycles, obs_fault); end
    n_cmp++; if (obs_rw !== 1'b0 || obs_done_cycle !== 1) begin n_fail++; $display("FAIL rdwr_resp: got rw=%b done@%0d want 0/1", obs_rw, obs_done_cycle); end
  endtask

  task automatic test_timeout();
    do_txn(1, 0, 1, 5'd4, 32'h300, $urandom, $urandom, 1, $urandom, $urandom, 0);
    n_cmp++; if (obs_req_cycles !== TMO) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d want %0d", obs_req_cycles, TMO); end
    n_cmp++; if (obs_fault !== 1'b1 || obs_rw !== 1'b0 || obs_br !== 1'b0) begin n_fail++; $display("FAIL tmo_resp: got fault=%b rw=%b br=%b want 1/0/0", obs_fault, obs_rw, obs_br); end
    n_cmp++; if (obs_done_cycle !== TMO + 1 || obs_done_count !== 1) begin n_fail++; $display("FAIL tmo_done: got @%0d x%0d want @%0d x1", obs_done_cycle, obs_done_count, TMO + 1); end
    n_cmp++; if (obs_req_after_done !== 0 || obs_dbg !== 2'd2) begin n_fail++; $display("FAIL tmo_hold: got relaunch=%0d fsm=%0d want 0/2", obs_req_after_done, obs_dbg); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    state = 3'd3; mem_read_in = 1; mem_write_in = 0; reg_write_in = 1;
    mem_addr = 32'h200; dmem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_pre_req: got %b want 1", dmem_req); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_write_out, write_reg_out,
         reg_write_data_out, branch_out, branch_addr_out, done, mem_fault} !== '0) begin
      n_fail++; $display("FAIL rstw_immediate: got req=%b addr=%h want all 0", dmem_req, dmem_addr);
    end
    @(negedge clk);
    mem_read_in = 0; mem_write_in = 0; reg_write_in = 1; write_reg_in = 5'd9;
    reg_write_data_in = 32'h77;
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || reg_write_data_out !== 32'h77 || write_reg_out !== 5'd9 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstw_relaunch: got done=%b data=%h reg=%0d req=%b want 1/00000077/9/0", done, reg_write_data_out, write_reg_out, dmem_req);
    end
    state = 3'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        e;
    logic        rd, wr, rw, br;
    logic [31:0] addr, rdata, rwdata, baddr, wdata, got;
    logic [4:0]  wreg;
    int          kind, lat;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 4);
      rd = (kind == 1 || kind == 3 || kind == 4);
      wr = (kind == 2 || kind == 4);
      addr = $urandom & 32'hFFFF_FFFC;
      if (kind == 3) addr = addr | 32'($urandom_range(1, 3));
      rw = 1'($urandom); br = 1'($urandom); wreg = 5'($urandom);
      rdata = $urandom; rwdata = $urandom; baddr = $urandom; wdata = $urandom;
      lat = $urandom_range(0, 5);
      e = model(rd, wr, rw, addr, rwdata, rdata, br, lat);
      if (e.data_care) exp_q.push_back(e.data);
      do_txn(rd, wr, rw, wreg, addr, wdata, rwdata, br, baddr, rdata, lat);
      n_cmp++;
      if (obs_done_cycle !== e.done_cycle || obs_done_count !== 1 || obs_req_cycles !== e.req_cycles) begin
        n_fail++; $display("FAIL rnd%0d_timing: got done@%0d x%0d req=%0d want done@%0d x1 req=%0d", i, obs_done_cycle, obs_done_count, obs_req_cycles, e.done_cycle, e.req_cycles);
      end
      n_cmp++;
      if ({obs_fault, obs_rw, obs_br, obs_wreg, obs_baddr} !== {e.fault, e.rw, e.br, wreg, baddr}) begin
        n_fail++; $display("FAIL rnd%0d_ctrl: got f=%b rw=%b br=%b reg=%0d ba=%h want f=%b rw=%b br=%b reg=%0d ba=%h", i, obs_fault, obs_rw, obs_br, obs_wreg, obs_baddr, e.fault, e.rw, e.br, wreg, baddr);
      end
      if (e.data_care) begin
        got = exp_q.pop_front();
        n_cmp++;
        if (obs_data !== got) begin n_fail++; $display("FAIL rnd%0d_data: got %h want %h", i, obs_data, got); end
      end
      if (e.req_cycles > 0) begin
        n_cmp++;
        if ({obs_addr, obs_we, obs_unstable} !== {addr, wr, 1'b0} || (wr && obs_wdata !== wdata)) begin
          n_fail++; $display("FAIL rnd%0d_bus: got a=%h we=%b wd=%h unstable=%0d want a=%h we=%b wd=%h", i, obs_addr, obs_we, obs_wdata, obs_unstable, addr, wr, wdata);
        end
      end
      n_cmp++;
      if (obs_wb_unstable !== 0 || obs_req_after_done !== 0) begin
        n_fail++; $display("FAIL rnd%0d_hold: got wb_unstable=%0d relaunch=%0d want 0/0", i, obs_wb_unstable, obs_req_after_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage, directly downstream of the execute stage.
- Consumes execute results: mem_addr, mem_write_data, reg_write_data, control bits, branch info.
- Performs at most one word load/store per instruction over a req/ack data-memory handshake, then presents writeback data and branch info to the writeback/fetch logic.
- Pulses `done` so the global stage controller advances `state`.

Parameters:
- STATE_MEM, 3, value of `state` during which this stage operates
- TIMEOUT, 255, max cycles waiting for dmem_ack before fault (1..255; counter 8 bits)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- state  in  3  global stage counter
- mem_read_in  in  1  load request from execute
- mem_write_in  in  1  store request from execute
- reg_write_in  in  1  register writeback enable from execute
- write_reg_in  in  5  destination register
- mem_addr  in  32  byte address from ALU
- mem_write_data  in  32  store data
- reg_write_data_in  in  32  ALU result / link address
- branch_in  in  1  branch taken
- branch_addr_in  in  32  branch target
- dmem_req  out  1  memory request (level, held until ack)
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- dmem_ack  in  1  memory completion
- reg_write_out  out  1  writeback enable
- write_reg_out  out  5  destination register
- reg_write_data_out  out  32  writeback data
- branch_out  out  1  branch taken
- branch_addr_out  out  32  branch target
- done  out  1  one-cycle stage-complete pulse
- mem_fault  out  1  misaligned/illegal/timeout flag, held until next launch

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, timeout counter=0. Takes effect immediately, including mid-transaction: dmem_req drops without waiting for a clock edge.
- FSM states: IDLE, WAIT, HOLD.
- IDLE, state!=STATE_MEM: nothing happens.
- IDLE, state==STATE_MEM (launch edge):
  - Latch write_reg_in, branch_in, branch_addr_in into the outputs; clear mem_fault.
  - Fault cases: (mem_read_in & mem_write_in), or (read|write with mem_addr[1:0]!=0). Set mem_fault=1, reg_write_out=0, branch_out=0, done=1, go HOLD. No request is issued.
  - Memory op: dmem_req=1; dmem_we=mem_write_in; dmem_addr=mem_addr; dmem_wdata=mem_write_data. Latch reg_write_in as pending; counter=0; go WAIT.
  - No memory op: reg_write_out=reg_write_in; reg_write_data_out=reg_write_data_in; done=1; go HOLD.
- WAIT: at each edge, sample dmem_ack.
  - ack=1: dmem_req=0; reg_write_out=pending enable. reg_write_data_out=dmem_rdata for a load; for a store, reg_write_out=0. done=1; go HOLD.
  - ack=0 and counter==TIMEOUT-1: dmem_req=0; mem_fault=1; reg_write_out=0; branch_out=0; done=1; go HOLD.
  - Otherwise: counter+1.
  - dmem_addr, dmem_we and dmem_wdata remain stable while dmem_req=1.
- HOLD: done=0 after its single cycle. Stay in HOLD while state==STATE_MEM; go IDLE when state!=STATE_MEM. This gives exactly one launch per visit to STATE_MEM.
- dmem_ack outside WAIT is ignored.
- Latency:
  - Non-memory op: done high the cycle after the launch edge.
  - Memory op, ack present in the first req cycle: done 2 cycles after launch.
  - Timeout: done TIMEOUT+1 cycles after launch.
- Writeback outputs and branch outputs stay stable from the done pulse until the next launch.
- Inputs are sampled only at the launch edge; later changes have no effect.

Test Plan:
- ALU op: state=3, reg_write_in=1, write_reg_in=5, reg_write_data_in=0x2A, no mem. Required: done pulses 1 cycle later; reg_write_out=1, write_reg_out=5, reg_write_data_out=0x2A; dmem_req never asserted.
- Load: mem_read_in=1, mem_addr=0x100, reg_write_in=1; ack after 3 req cycles with dmem_rdata=0xDEADBEEF. Required: dmem_req high exactly 3 cycles at dmem_addr=0x100, dmem_we=0; reg_write_data_out=0xDEADBEEF; single done pulse.
- Store: mem_write_in=1, mem_addr=0x44, mem_write_data=0x12345678; immediate ack. Required: dmem_we=1, dmem_wdata=0x12345678; reg_write_out=0; done 2 cycles after launch.
- Faults:
  - mem_read_in=1, mem_addr=0x102. Required: no dmem_req, mem_fault=1, reg_write_out=0, done next cycle.
  - Both read and write set. Required: same fault response.
- Timeout, TIMEOUT=4, ack held 0. Required: req high 4 cycles then drops; mem_fault=1; done pulses once; FSM stays in HOLD while state remains 3; no relaunch.
- Reset: rst=0 asserted mid-WAIT between edges. Required: dmem_req drops immediately; all outputs 0. After release with state=3, a fresh launch occurs.
